// File: rtl/uart_rx_os.sv
// -----------------------------------------------------------------------------
// uart_rx_os
//
// Oversampling UART receiver. Recovers bytes framed as: start bit (0), eight
// data bits MSB first, an optional even-parity bit, and a stop bit (1). The
// asynchronous serial line is passed through a two-flop synchroniser. The
// receiver validates the start bit at half-bit and samples every following
// bit at mid-period. Each received byte is handed to the consumer over a
// valid/ready handshake, together with its error flags.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : the frame carries an even-parity bit after the data bits, and
//               parity_error reports a mismatch.
//   undefined : there is no parity bit. DATA goes straight to STOP, and
//               parity_error is tied to 0.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (integer >= 4)
//
// Ports:
//   clk           in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   rx_in         in   serial line, idle high, asynchronous to clk
//   rx_data       out  received byte, stable while rx_valid=1
//   rx_valid      out  byte available, held until accepted
//   rx_ready      in   consumer accepts the byte when rx_valid & rx_ready
//   parity_error  out  parity mismatch for the byte in rx_data
//   frame_error   out  stop bit sampled 0 for the byte in rx_data
//   overrun       out  sticky: a completed frame was dropped because rx_data
//                      was still held
//   busy          out  high from start-edge detection until return to IDLE
//
// Handshake: a byte transfers in every cycle where rx_valid & rx_ready are
// both high. Once rx_valid is raised, it stays high, and rx_data and the error
// flags stay stable, until that transfer happens. A frame that completes in
// the same cycle as a transfer replaces the outgoing byte, so rx_valid stays
// high without a gap.
//
// The FSM state is held in state_q, and the baud and bit counters are held in
// baud_q and bit_q.
// -----------------------------------------------------------------------------
module uart_rx_os #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_error,
    output logic       frame_error,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF   = CLKS_PER_BIT / 2;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(HALF - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

    // -------------------------------------------------------------------------
    // Synchroniser and edge-detect history
    // -------------------------------------------------------------------------
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic s_prev_q, s_prev_d;
    logic s;

    assign sync1_d  = rx_in;
    assign sync2_d  = sync1_q;
    assign s        = sync2_q;
    assign s_prev_d = s;

    // -------------------------------------------------------------------------
    // Receive FSM state
    // -------------------------------------------------------------------------
    logic [2:0]        state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
`ifdef UART_RX_PARITY_EN
    logic              par_err_q, par_err_d;
`endif

    // -------------------------------------------------------------------------
    // Output holding registers
    // -------------------------------------------------------------------------
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       frame_error_q, frame_error_d;
    logic       overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic       parity_error_q, parity_error_d;
`endif

    logic baud_tick;
    logic half_tick;
    logic frame_done;
    logic accept;
    logic load;

    assign baud_tick = (baud_q == BAUD_LAST);
    assign half_tick = (baud_q == HALF_LAST);
    assign accept    = rx_valid_q & rx_ready;

    // -------------------------------------------------------------------------
    // FSM next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
`ifdef UART_RX_PARITY_EN
        par_err_d  = par_err_q;
`endif
        frame_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A falling edge needs s_prev_q = 1. After a stop bit
                // sampled low, the line must first be seen high, so a
                // held break cannot retrigger reception.
                if (s_prev_q && !s) begin
                    state_d = ST_START;
                    baud_d  = '0;
                end
            end

            ST_START: begin
                baud_d = baud_q + BAUD_ONE;
                if (half_tick) begin
                    baud_d = '0;
                    bit_d  = '0;
                    // If the line is already high again, the edge was a
                    // glitch, so drop back to IDLE.
                    state_d = s ? ST_IDLE : ST_DATA;
                end
            end

            ST_DATA: begin
                baud_d = baud_q + BAUD_ONE;
                if (baud_tick) begin
                    baud_d  = '0;
                    shift_d = {shift_q[6:0], s};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                baud_d = baud_q + BAUD_ONE;
                if (baud_tick) begin
                    baud_d    = '0;
                    // With even parity, the XOR over the data bits and the
                    // parity bit together is 0.
                    par_err_d = s ^ (^shift_q);
                    state_d   = ST_STOP;
                end
            end
`endif

            ST_STOP: begin
                baud_d = baud_q + BAUD_ONE;
                if (baud_tick) begin
                    baud_d     = '0;
                    frame_done = 1'b1;
                    state_d    = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Delivery and handshake
    //
    // A completed frame is loaded when the holding register is empty, or is
    // being emptied in this same cycle. Otherwise the frame is dropped, the
    // held byte and its flags are kept, and overrun is set.
    // -------------------------------------------------------------------------
    assign load = frame_done & (~rx_valid_q | rx_ready);

    always_comb begin
        rx_data_d      = rx_data_q;
        rx_valid_d     = rx_valid_q;
        frame_error_d  = frame_error_q;
        overrun_d      = overrun_q;
`ifdef UART_RX_PARITY_EN
        parity_error_d = parity_error_q;
`endif

        if (load) begin
            rx_valid_d     = 1'b1;
            rx_data_d      = shift_q;
            // The stop bit is sampled in the same cycle as frame_done.
            frame_error_d  = ~s;
`ifdef UART_RX_PARITY_EN
            parity_error_d = par_err_q;
`endif
        end else if (accept) begin
            rx_valid_d = 1'b0;
        end

        if (accept) begin
            overrun_d = 1'b0;
        end else if (frame_done && !load) begin
            overrun_d = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q        <= 1'b1;
            sync2_q        <= 1'b1;
            s_prev_q       <= 1'b1;
            state_q        <= ST_IDLE;
            baud_q         <= '0;
            bit_q          <= '0;
            shift_q        <= '0;
`ifdef UART_RX_PARITY_EN
            par_err_q      <= 1'b0;
            parity_error_q <= 1'b0;
`endif
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            frame_error_q  <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            s_prev_q       <= s_prev_d;
            state_q        <= state_d;
            baud_q         <= baud_d;
            bit_q          <= bit_d;
            shift_q        <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_err_q      <= par_err_d;
            parity_error_q <= parity_error_d;
`endif
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            frame_error_q  <= frame_error_d;
            overrun_q      <= overrun_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;
    assign busy        = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_error = parity_error_q;
`else
    assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_os
//
// Self-checking bench for uart_rx_os. Frames are driven bit by bit on the
// falling clock edge. When a frame is sent, the expected {frame_error,
// parity_error, rx_data} is pushed to exp_q. The entry is popped and compared
// when the DUT presents the byte. The bench follows the UART_RX_PARITY_EN
// build option.
// -----------------------------------------------------------------------------
module tb_uart_rx_os;

  localparam int C    = 16;
  localparam int HALF = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int NBITS  = 11;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int NBITS  = 10;
`endif
  // Frame length in cycles
  localparam int FL  = NBITS * C;
  // Cycles from the negedge that drives the start bit to the first negedge
  // that sees rx_valid high: 2 sync cycles + (half + (NBITS-1)*C) + 1
  localparam int LAT = 2 + HALF + (NBITS - 1) * C + 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_in = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_error;
  logic       frame_error;
  logic       overrun;
  logic       busy;

  logic [9:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  uart_rx_os #(.CLKS_PER_BIT(C)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rx_in(rx_in),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .parity_error(parity_error),
    .frame_error(frame_error),
    .overrun(overrun),
    .busy(busy)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks (called on a negedge) ----------------
  task automatic send_frame(input logic [7:0] d, input bit flip_par,
                            input bit stop_b, input bit deliver);
    if (deliver) exp_q.push_back({~stop_b, PAR_EN & flip_par, d});
    rx_in = 1'b0;
    repeat (C) @(negedge clk);
    for (int k = 7; k >= 0; k--) begin
      rx_in = d[k];
      repeat (C) @(negedge clk);
    end
    if (PAR_EN) begin
      rx_in = (^d) ^ flip_par;
      repeat (C) @(negedge clk);
    end
    rx_in = stop_b;
    repeat (C) @(negedge clk);
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (rx_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic accept_pulse();
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int seen;
    reset_n = 1'b0;
    rx_in = 1'b1;
    rx_ready = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({rx_data, rx_valid, parity_error, frame_error, overrun, busy} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_values: got data=%h v=%b pe=%b fe=%b ov=%b busy=%b, want all 0",
               rx_data, rx_valid, parity_error, frame_error, overrun, busy);
    end
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (rx_valid || busy) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL reset_idle: %0d cycles with rx_valid/busy high, want 0", seen);
    end
  endtask

  task automatic test_basic();
    int  rise;
    bit  busy_pre, busy_at;
    logic [9:0] exp;
    rise = 0;
    busy_pre = 1'b0;
    busy_at = 1'b1;
    fork
      send_frame(8'h67, 1'b0, 1'b1, 1'b1);
      begin
        for (int i = 1; i <= LAT + 8; i++) begin
          @(negedge clk);
          if (rx_valid && rise == 0) begin
            rise = i;
            busy_at = busy;
          end
          if (i == LAT - 1) busy_pre = busy;
        end
      end
    join
    n_cmp++;
    if (rise !== LAT) begin
      n_err++;
      $display("FAIL basic_latency: rx_valid rose after %0d cycles, want %0d", rise, LAT);
    end
    n_cmp++;
    if ({busy_pre, busy_at} !== 2'b10) begin
      n_err++;
      $display("FAIL basic_busy_fall: busy before/at rise = %b%b, want 10", busy_pre, busy_at);
    end
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    n_cmp++;
    if ({frame_error, parity_error, rx_data} !== exp || !rx_valid) begin
      n_err++;
      $display("FAIL basic_byte: got v=%b {fe,pe,data}=%h, want v=1 %h",
               rx_valid, {frame_error, parity_error, rx_data}, exp);
    end
    accept_pulse();
    n_cmp++;
    if (rx_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_accept: rx_valid=%b after accept, want 0", rx_valid);
    end
  endtask

  task automatic test_parity();
    bit ok;
    logic [9:0] exp;
    send_frame(8'hB5, 1'b1, 1'b1, 1'b1);
    wait_valid(4 * C, ok);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    n_cmp++;
    if (!ok || {frame_error, parity_error, rx_data} !== exp) begin
      n_err++;
      $display("FAIL parity_byte: got ok=%b {fe,pe,data}=%h, want ok=1 %h",
               ok, {frame_error, parity_error, rx_data}, exp);
    end
    accept_pulse();
  endtask

  task automatic test_frame_err();
    bit ok;
    int busy_seen;
    logic [9:0] exp;
    send_frame(8'h6C, 1'b0, 1'b0, 1'b1);
    wait_valid(4 * C, ok);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    n_cmp++;
    if (!ok || {frame_error, parity_error, rx_data} !== exp) begin
      n_err++;
      $display("FAIL frame_err_byte: got ok=%b {fe,pe,data}=%h, want ok=1 %h",
               ok, {frame_error, parity_error, rx_data}, exp);
    end
    busy_seen = 0;
    repeat (3 * C) begin
      @(negedge clk);
      if (busy) busy_seen++;
    end
    n_cmp++;
    if (busy_seen !== 0) begin
      n_err++;
      $display("FAIL break_no_retrigger: busy high %0d cycles while line low, want 0", busy_seen);
    end
    rx_in = 1'b1;
    repeat (2 * C) @(negedge clk);
    accept_pulse();
  endtask

  task automatic test_glitch();
    bit busy_seen, valid_seen;
    busy_seen = 1'b0;
    valid_seen = 1'b0;
    rx_in = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    rx_in = 1'b1;
    repeat (3 * C) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
      if (rx_valid) valid_seen = 1'b1;
    end
    n_cmp++;
    if ({busy_seen, valid_seen, busy} !== 3'b100) begin
      n_err++;
      $display("FAIL glitch: busy_seen=%b valid_seen=%b busy_end=%b, want 1 0 0",
               busy_seen, valid_seen, busy);
    end
  endtask

  task automatic test_overrun();
    bit ok;
    logic [9:0] exp;
    send_frame(8'h01, 1'b0, 1'b1, 1'b1);
    send_frame(8'h02, 1'b0, 1'b1, 1'b0);
    wait_valid(4 * C, ok);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    n_cmp++;
    if (!ok || {frame_error, parity_error, rx_data} !== exp || overrun !== 1'b1) begin
      n_err++;
      $display("FAIL overrun_hold: got ok=%b {fe,pe,data}=%h ov=%b, want ok=1 %h ov=1",
               ok, {frame_error, parity_error, rx_data}, overrun, exp);
    end
    accept_pulse();
    n_cmp++;
    if ({rx_valid, overrun} !== 2'b00) begin
      n_err++;
      $display("FAIL overrun_clear: v=%b ov=%b after accept, want 0 0", rx_valid, overrun);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp;
    fork
      begin
        send_frame(8'h01, 1'b0, 1'b1, 1'b1);
        send_frame(8'h02, 1'b0, 1'b1, 1'b1);
      end
      begin
        repeat (FL + LAT - 1) @(negedge clk);
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        n_cmp++;
        if (!rx_valid || {frame_error, parity_error, rx_data} !== exp) begin
          n_err++;
          $display("FAIL b2b_first: v=%b {fe,pe,data}=%h, want v=1 %h",
                   rx_valid, {frame_error, parity_error, rx_data}, exp);
        end
        // Ready is high over exactly the clock edge that loads the second frame.
        accept_pulse();
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
        n_cmp++;
        if (!rx_valid || overrun || {frame_error, parity_error, rx_data} !== exp) begin
          n_err++;
          $display("FAIL b2b_second: v=%b ov=%b {fe,pe,data}=%h, want v=1 ov=0 %h",
                   rx_valid, overrun, {frame_error, parity_error, rx_data}, exp);
        end
      end
    join
    accept_pulse();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int seen;
    logic [9:0] exp;
    rx_in = 1'b0;
    repeat (C) @(negedge clk);
    rx_in = 1'b1;
    repeat (3 * C) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_busy: busy=%b in data phase, want 1", busy);
    end
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (12 * C) begin
      @(negedge clk);
      if (rx_valid || busy) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_err++;
      $display("FAIL mid_reset_abandon: %0d cycles with rx_valid/busy high, want 0", seen);
    end
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
    wait_valid(4 * C, ok);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    n_cmp++;
    if (!ok || {frame_error, parity_error, rx_data} !== exp) begin
      n_err++;
      $display("FAIL after_reset_byte: got ok=%b {fe,pe,data}=%h, want ok=1 %h",
               ok, {frame_error, parity_error, rx_data}, exp);
    end
    accept_pulse();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d expected bytes never delivered, want 0", exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_parity();
    test_frame_err();
    test_glitch();
    test_overrun();
    repeat (C) @(negedge clk);
    test_back_to_back();
    repeat (C) @(negedge clk);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
